// File: rtl/maquina_senha_if.sv
// Keypad-side and display-side signals of the code lock, bundled for the lock core.
// master = keypad/display side, slave = the lock itself.
interface maquina_senha_if;
    logic       insere;
    logic [4:1] numero;
    logic       LED;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic       E;
    logic       F;
    logic       G;

    modport master (
        output insere, numero,
        input  LED, A, B, C, D, E, F, G
    );

    modport slave (
        input  insere, numero,
        output LED, A, B, C, D, E, F, G
    );
endinterface

// File: rtl/maquina_senha.sv
// Seven-digit code lock (5-9-0-1-9-8-1) with a 7-segment echo of the last accepted digit.
// LED latches high once the full code is entered in order and stays high until reset.
module maquina_senha (
    input logic        clk,
    input logic        reset,
    maquina_senha_if.slave bus
);

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_t;

    state_t     state;
    state_t     state_next;
    logic       ins_q;
    logic       accept;
    logic       led;
    logic [6:0] seg;
    logic [6:0] seg_next;

    function automatic logic [3:0] code_digit(input state_t s);
        case (s)
            S0:      code_digit = 4'd5;
            S1:      code_digit = 4'd9;
            S2:      code_digit = 4'd0;
            S3:      code_digit = 4'd1;
            S4:      code_digit = 4'd9;
            S5:      code_digit = 4'd8;
            S6:      code_digit = 4'd1;
            default: code_digit = 4'd15;
        endcase
    endfunction

    // Segment order is {a,b,c,d,e,f,g}; non-BCD values show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1111110;
            4'd1:    seg_decode = 7'b0110000;
            4'd2:    seg_decode = 7'b1101101;
            4'd3:    seg_decode = 7'b1111001;
            4'd4:    seg_decode = 7'b0110011;
            4'd5:    seg_decode = 7'b1011011;
            4'd6:    seg_decode = 7'b1011111;
            4'd7:    seg_decode = 7'b1110000;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1111011;
            default: seg_decode = 7'b0000001;
        endcase
    endfunction

    assign accept = bus.insere & ~ins_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S0;
            ins_q <= 1'b0;
            seg   <= 7'b0000000;
            led   <= 1'b0;
        end else begin
            state <= state_next;
            ins_q <= bus.insere;
            seg   <= seg_next;
            led   <= (state_next == S7);
        end
    end

    // The code's only self-overlap is its leading 5, so a wrong 5 restarts at S1.
    always_comb begin
        state_next = state;
        seg_next   = seg;
        if (accept) begin
            seg_next = seg_decode(bus.numero);
            if (state != S7) begin
                if (bus.numero == code_digit(state)) begin
                    state_next = state_t'(state + 3'd1);
                end else if (bus.numero == 4'd5) begin
                    state_next = S1;
                end else begin
                    state_next = S0;
                end
            end
        end
    end

    assign bus.LED = led;
    assign {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G} = seg;

endmodule

// File: tb/tb_maquina_senha.sv
// Self-checking bench for maquina_senha: directed code-entry scenarios followed by
// randomized bursts, checked against a digit-history reference model.
module tb_maquina_senha;

    logic clk;
    logic reset;
    maquina_senha_if bus ();

    maquina_senha dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         compared;
    int         mismatched;
    logic       exp_led;
    logic [6:0] exp_seg;
    logic       prev_ins;
    int         hist[$];
    int         code[7] = '{5, 9, 0, 1, 9, 8, 1};

    // Display reference written from the segment lists, order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] segTable(input int d);
        case (d)
            0:       return 7'b1111110;
            1:       return 7'b0110000;
            2:       return 7'b1101101;
            3:       return 7'b1111001;
            4:       return 7'b0110011;
            5:       return 7'b1011011;
            6:       return 7'b1011111;
            7:       return 7'b1110000;
            8:       return 7'b1111111;
            9:       return 7'b1111011;
            default: return 7'b0000001;
        endcase
    endfunction

    // Unlocked once the last seven accepted digits spell the code; sticky until reset.
    task automatic modelAccept(input int d);
        bit match;
        exp_seg = segTable(d);
        hist.push_back(d);
        if (hist.size() > 7) void'(hist.pop_front());
        if (hist.size() == 7) begin
            match = 1'b1;
            for (int i = 0; i < 7; i++) if (hist[i] != code[i]) match = 1'b0;
            if (match) exp_led = 1'b1;
        end
    endtask

    task automatic modelReset();
        exp_led  = 1'b0;
        exp_seg  = 7'b0000000;
        prev_ins = 1'b0;
        hist.delete();
    endtask

    task automatic checkOutput(input string tag);
        logic [6:0] seg_obs;
        seg_obs = {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G};
        compared++;
        assert (bus.LED === exp_led) else begin
            mismatched++;
            $error("[TB] FAIL %s led: observed %b expected %b", tag, bus.LED, exp_led);
        end
        compared++;
        assert (seg_obs === exp_seg) else begin
            mismatched++;
            $error("[TB] FAIL %s seg: observed %b expected %b", tag, seg_obs, exp_seg);
        end
    endtask

    task automatic applyStimulus(input logic ins, input int num, input string tag);
        @(negedge clk);
        bus.insere = ins;
        bus.numero = 4'(num);
        @(posedge clk);
        if (ins && !prev_ins) modelAccept(num);
        prev_ins = ins;
        #1;
        checkOutput(tag);
    endtask

    task automatic pulse(input int d, input string tag);
        applyStimulus(1'b1, d, tag);
        applyStimulus(1'b0, d, tag);
    endtask

    task automatic enterCode(input string tag);
        for (int i = 0; i < 7; i++) pulse(code[i], tag);
    endtask

    // Reset is dropped between edges to exercise its asynchronous path.
    task automatic doReset(input string tag);
        @(negedge clk);
        bus.insere = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        bus.insere = 1'b0;
        bus.numero = 4'd0;
        reset      = 1'b1;
        modelReset();
        #3;
        doReset("reset_init");
        applyStimulus(1'b0, 5, "idle_no_strobe");
        applyStimulus(1'b0, 9, "numero_change_no_strobe");

        enterCode("correct_code");
        pulse(0, "unlocked_then_0");

        doReset("reset_after_unlock");
        foreach (code[i]) if (i != 3) pulse(code[i], "wrong_4th");
        enterCode("code_after_wrong_4th");

        doReset("reset_before_wrong_5th");
        pulse(5, "w5"); pulse(9, "w5"); pulse(0, "w5"); pulse(1, "w5");
        pulse(2, "w5"); pulse(8, "w5"); pulse(1, "w5");
        doReset("reset_mid_stream");
        enterCode("code_after_reset");

        doReset("reset_before_hold");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5, "hold_5");
        applyStimulus(1'b0, 5, "hold_release");
        for (int i = 1; i < 7; i++) pulse(code[i], "after_hold");

        doReset("reset_before_restart");
        pulse(5, "restart"); pulse(9, "restart");
        enterCode("restart_code");

        pulse(3, "unlocked_3");
        pulse(12, "unlocked_dash");
        pulse(15, "unlocked_dash_f");

        doReset("reset_before_random");
        for (int burst = 0; burst < 60; burst++) begin
            int mode;
            mode = $urandom_range(0, 9);
            if (mode < 4) begin
                int len;
                len = $urandom_range(1, 8);
                for (int j = 0; j < len; j++)
                    applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 15), "rand_noise");
            end else if (mode < 9) begin
                for (int i = 0; i < 7; i++) begin
                    int hold;
                    int gap;
                    hold = $urandom_range(1, 3);
                    gap  = $urandom_range(1, 2);
                    for (int h = 0; h < hold; h++) applyStimulus(1'b1, code[i], "rand_code_hold");
                    for (int g = 0; g < gap; g++)
                        applyStimulus(1'b0, $urandom_range(0, 15), "rand_code_gap");
                end
            end else begin
                doReset("rand_reset");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
